izq_der_serial_comparator: RTL
==============================

// Module: izq_der_serial_comparator
// PURPOSE
//   Sequential magnitude comparator for two WIDTH-bit unsigned operands A and B.
//   Scans one bit pair per clock, left to right (MSB first), and stops at the first differing bit.
//   It is the scan-direction counterpart of the right-to-left (der-izq) blocks.
//   It consumes the same A/B operand pair the der-izq bench drives, under a start/done handshake.
// PARAMETERS
//   WIDTH  5  operand width in bits; must be >= 2
//   POS_W  3  width of diff_pos; must be >= $clog2(WIDTH)
// PORTS
//   clk       in   1      single clock; all state updates on rising edge
//   reset     in   1      synchronous, active-high reset
//   start     in   1      request a compare; sampled only in IDLE
//   A         in   WIDTH  operand A; captured when start is accepted
//   B         in   WIDTH  operand B; captured when start is accepted
//   busy      out  1      high while in SCAN
//   done      out  1      one-cycle pulse; result fields are valid from this cycle on
//   gt        out  1      A > B
//   eq        out  1      A == B
//   lt        out  1      A < B
//   diff_pos  out  POS_W  index of the highest differing bit; 0 when eq
// BEHAVIOUR
//   Reset, sampled at a clock edge:
//     - FSM goes to IDLE.
//     - busy, done, gt, eq, lt and diff_pos are all 0.
//     - Internal operand registers and bit index are cleared.
//     - Reset takes priority over every other input, including mid-SCAN.
//     - An aborted scan produces no done pulse.
//   FSM states: IDLE, SCAN, DONE.
//   IDLE:
//     - start=1 -> capture A, B into internal registers; idx <= WIDTH-1.
//     - Clear gt/eq/lt/diff_pos; go to SCAN.
//     - start=0 -> stay in IDLE; result fields hold their last values.
//   SCAN (busy=1): each cycle compares a_r[idx] against b_r[idx].
//     - Bits differ -> gt <= a_r[idx]; lt <= b_r[idx]; diff_pos <= idx; go to DONE.
//     - Bits equal and idx == 0 -> eq <= 1; diff_pos <= 0; go to DONE.
//     - Bits equal and idx > 0 -> idx <= idx-1; stay in SCAN.
//   DONE:
//     - done=1 and busy=0 for exactly one cycle, then go to IDLE unconditionally.
//     - start is ignored in DONE.
//   Latency:
//     - Let k be the highest differing bit. SCAN lasts WIDTH-k cycles (WIDTH cycles when equal).
//     - done is high in the cycle after the last SCAN cycle.
//     - With start accepted at edge t0: done is high in cycle t0+(WIDTH-k)+1 (k=0 when equal).
//   Handshake:
//     - start is ignored while busy or done is high; no queuing.
//     - Earliest re-issue is the cycle after done, i.e. back-to-back in IDLE.
//     - A and B may change freely after the accepting edge; only the captured copies are compared.
//   Result invariants:
//     - Exactly one of gt/eq/lt is 1 from done until the next accepted start; all are 0 during SCAN.
//     - Results hold in IDLE until the next accepted start clears them.
//   Boundaries:
//     - A=B=0 -> full WIDTH-cycle scan, eq=1.
//     - Difference only in the LSB -> full WIDTH-cycle scan, diff_pos=0.
//     - idx never wraps below 0.
//     - start and reset high together -> reset wins, FSM stays in IDLE.
// TESTING
//   1. A=11001, B=10010, start pulse -> 2 SCAN cycles; done with gt=1, diff_pos=3.
//   2. A=11101, B=01100 -> 1 SCAN cycle; gt=1, diff_pos=4.
//      A=00101, B=10001 -> 1 SCAN cycle; lt=1, diff_pos=4.
//   3. A=01111, B=00111 -> 2 SCAN cycles; gt=1, diff_pos=3.
//      A=10101, B=10101 -> 5 SCAN cycles; eq=1, diff_pos=0.
//   4. Start A=10000, B=10001; change A to 11111 in the first SCAN cycle.
//      -> Result still lt=1, diff_pos=0 after 5 SCAN cycles (captured operands used).
//   5. Start A=00000, B=00001; pulse start again in SCAN cycle 2 -> second start ignored.
//      Reset in SCAN cycle 3 -> next cycle IDLE, all outputs 0, no done pulse.
//   6. Back-to-back: start in the cycle after done with A=00010, B=00011.
//      -> Accepted; gt/eq/lt clear on acceptance; lt=1, diff_pos=0 after 5 SCAN cycles.

Source files
------------

// File: rtl/izq_der_serial_comparator.sv
// MSB-first serial magnitude comparator: scans one bit pair per clock and
// stops at the first differing bit, reporting gt/eq/lt and its position.
module izq_der_serial_comparator #(
  parameter int WIDTH = 5,
  parameter int POS_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt,
  output logic [POS_W-1:0] diff_pos
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [POS_W-1:0] idx_q, idx_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             gt_q, gt_d;
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;

  // Operands are shifted left each SCAN step, so the bit pair under test is
  // always the MSB and idx only tracks its original position.
  logic a_msb, b_msb;
  assign a_msb = a_q[WIDTH-1];
  assign b_msb = b_q[WIDTH-1];

  // NOTE: non-blocking assignments here so every register updates from the
  // same pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      pos_q   <= '0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      pos_q   <= pos_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
    end
  end

  // NOTE: every _d takes its _q value first, so no branch can leave a
  // signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    pos_d   = pos_q;
    gt_d    = gt_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          idx_d   = POS_W'(WIDTH - 1);
          pos_d   = '0;
          gt_d    = 1'b0;
          eq_d    = 1'b0;
          lt_d    = 1'b0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (a_msb != b_msb) begin
          gt_d    = a_msb;
          lt_d    = b_msb;
          pos_d   = idx_q;
          state_d = DONE;
        end else if (idx_q == '0) begin
          eq_d    = 1'b1;
          pos_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q - POS_W'(1);
          a_d   = a_q << 1;
          b_d   = b_q << 1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q == SCAN);
    done     = (state_q == DONE);
    gt       = gt_q;
    eq       = eq_q;
    lt       = lt_q;
    diff_pos = pos_q;
  end

endmodule
